// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
// Runtime-programmable serial bit-pattern detector. Takes one bit per in_valid
// cycle. It compares the most recent len_r bits with the low len_r bits of the
// programmed pattern. The first bit received of a pattern sits at
// pattern[len-1], and the last bit sits at pattern[0].
//
// Detection can be overlapping or non-overlapping. Matches are counted in a
// saturating counter. An illegal length (0 or > MAX_LEN) raises cfg_err and
// suppresses all matches until a legal load or a reset.
//
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset; defaults to "1011", overlap
//   in_valid     qualifies in_bit. There is no back-pressure: a bit is
//                consumed on every cycle where in_valid=1, unless cfg_load=1.
//   in_bit       serial data bit
//   cfg_load     one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap and
//                discards the same-cycle in_bit
//   cfg_pattern  pattern, right-aligned
//   cfg_len      pattern length
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   clr_count    synchronous clear of match_count; wins over a same-cycle hit
//   match        registered one-cycle pulse per detected pattern
//   match_count  saturating match count
//   cfg_err      high while the latched configuration is illegal
// -----------------------------------------------------------------------------
module seq_det_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] history_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  always_comb begin
    history_next = {history[MAX_LEN-2:0], in_bit};
    fill_next    = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

    // Only the low len_r bits take part in the compare. With an illegal
    // len_r the mask is don't-care, because cfg_err already blocks hits.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end

    // fill_next >= len_r guarantees every compared bit arrived after the
    // last clear (a load, or a non-overlapping hit).
    hit = in_valid && !cfg_load && !cfg_err && (fill_next >= len_r) &&
          ((history_next & len_mask) == (pattern_r & len_mask));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pattern_r   <= MAX_LEN'(4'b1011);
      len_r       <= LEN_W'(4);
      overlap_r   <= 1'b1;
      history     <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      match <= 1'b0;

      if (cfg_load) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        history   <= '0;
        fill      <= '0;
        cfg_err   <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
      end else if (in_valid) begin
        history <= history_next;
        // A non-overlapping hit restarts progress; history keeps shifting.
        fill    <= (hit && !overlap_r) ? '0 : fill_next;
        match   <= hit;
      end

      if (clr_count) begin
        match_count <= '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_det_prog
// Self-checking bench for seq_det_prog (MAX_LEN=8, CNT_W=4). A reference model
// keeps the bits received since the last clear in a queue. It declares a hit
// when the newest len bits, read newest-first, equal pattern[0..len-1]. Every
// cycle it pushes the expected {cfg_err, match, match_count} word into exp_q.
// After the active edge that word is compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_count   (clr_count),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  // ---------------- scoreboard ----------------
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  logic [CNT_W+1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h exp=%0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_err;
  int               m_cnt;

  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (!rstn) begin
      m_bits.delete();
      m_pat = MAX_LEN'(8'b0000_1011);
      m_len = 4;
      m_ovl = 1'b1;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (cfg_load) begin
        m_bits.delete();
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        m_err = (m_len == 0) || (m_len > MAX_LEN);
      end else if (in_valid) begin
        m_bits.push_back(in_bit);
        // Only the last MAX_LEN bits can ever be compared.
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (!m_err && m_bits.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++) begin
            if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
          end
        end
        if (hit && !m_ovl) m_bits.delete();
      end
      if (clr_count) m_cnt = 0;
      else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    exp_q.push_back({m_err, hit, CNT_W'(m_cnt)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [CNT_W+1:0] e;
    @(posedge clk);
    model_step();
    #1;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("cfg_err", 32'(cfg_err), 32'(e[CNT_W+1]));
      check_val("match", 32'(match), 32'(e[CNT_W]));
      check_val("match_count", 32'(match_count), 32'(e[CNT_W-1:0]));
    end
  endtask

  task automatic set_idle();
    rstn        = 1'b1;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    clr_count   = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    tick();
    set_idle();
  endtask

  task automatic send(input bit v, input bit b);
    set_idle();
    in_valid = v;
    in_bit   = b;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i]);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len,
                          input bit ovl);
    set_idle();
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    in_valid    = 1'b1;        // must be discarded
    in_bit      = 1'($urandom_range(0, 1));
    tick();
    set_idle();
  endtask

  task automatic clear_count();
    set_idle();
    clr_count = 1'b1;
    tick();
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    rstn        = 1'b0;

    phase = "reset";
    do_reset();
    check_val("rst_count", 32'(match_count), 32'd0);

    phase = "default_1011011";
    send_bits(32'b1011011, 7);
    check_val("count", 32'(match_count), 32'd2);
    send(1'b0, 1'b0);

    phase = "len3_nonovl";
    clear_count();
    load_cfg(8'b0000_0111, 3, 1'b0);
    send_bits(32'b111111, 6);
    check_val("count", 32'(match_count), 32'd2);

    phase = "len3_ovl";
    clear_count();
    load_cfg(8'b0000_0111, 3, 1'b1);
    send_bits(32'b111111, 6);
    check_val("count", 32'(match_count), 32'd4);

    phase = "idle_gaps";
    clear_count();
    load_cfg(8'b0000_1011, 4, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    check_val("count", 32'(match_count), 32'd1);

    phase = "cfg_err_len0";
    clear_count();
    load_cfg(8'b0000_0001, 0, 1'b1);
    check_val("err_flag", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 16; i++) send(1'b1, 1'($urandom_range(0, 1)));
    check_val("count", 32'(match_count), 32'd0);

    phase = "cfg_err_len9";
    load_cfg(8'b0000_1011, MAX_LEN + 1, 1'b1);
    check_val("err_flag", 32'(cfg_err), 32'd1);
    send_bits(32'b1011011, 7);
    check_val("count", 32'(match_count), 32'd0);

    phase = "cfg_err_recover";
    load_cfg(8'b0000_1011, 4, 1'b1);
    check_val("err_flag", 32'(cfg_err), 32'd0);
    send_bits(32'b1011, 4);
    check_val("count", 32'(match_count), 32'd1);

    phase = "saturate";
    clear_count();
    load_cfg(8'b0000_0001, 1, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b1);
    check_val("count_sat", 32'(match_count), 32'd15);

    phase = "clr_on_hit";
    set_idle();
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    clr_count = 1'b1;
    tick();
    check_val("match_pulse", 32'(match), 32'd1);
    check_val("count_clr", 32'(match_count), 32'd0);
    set_idle();

    phase = "mid_reset";
    do_reset();
    send_bits(32'b101, 3);
    do_reset();
    send(1'b1, 1'b1);
    check_val("no_match", 32'(match), 32'd0);
    send_bits(32'b011, 3);
    check_val("count", 32'(match_count), 32'd1);

    phase = "random";
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        load_cfg(MAX_LEN'($urandom),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                             : $urandom_range(1, 4),
                 1'($urandom_range(0, 1)));
      end else if (r < 5) begin
        clear_count();
      end else if (r < 6) begin
        do_reset();
      end else begin
        send(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Generalises the fixed-pattern detector to any pattern length from 1 to MAX_LEN.
- Adds selectable overlapping/non-overlapping detection, an input qualifier, a saturating match counter and configuration error reporting.
- Sits on a serial bit stream: 1 bit per in_valid cycle. Reset defaults detect "1011", overlapping.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits; legal range 2..32.
- CNT_W, 16, match counter width.
- LEN_W, $clog2(MAX_LEN+1), derived local parameter; width of the length field. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  qualifies in_bit; the bit is sampled only when high.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse per detected pattern; registered.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  high while the latched configuration is illegal.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - history=0, fill=0, match=0, match_count=0, cfg_err=0.
  - pattern_r = 4'b1011 zero-extended, len_r=4, overlap_r=1.
- State:
  - history[MAX_LEN-1:0] is a shift register; history[0] holds the newest bit.
  - fill is a count of valid bits since the last clear, saturating at MAX_LEN.
- On an in_valid cycle (no cfg_load):
  - history <= {history[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Hit condition, evaluated on the post-shift history:
  - in_valid=1, cfg_err=0, fill_next >= len_r, and history_next[len_r-1:0] == pattern_r[len_r-1:0].
- Latency: a hit sets match=1 on the clk edge that samples the completing bit, so it is visible the following cycle. match is 0 on every cycle without a hit.
- Overlap mode: history and fill are kept after a hit. Stream 1011011 gives 2 matches.
- Non-overlap mode: a hit forces fill <= 0; history still shifts. Stream 1011011 gives 1 match.
- in_valid=0: history, fill unchanged; match=0.
- cfg_load=1:
  - Latch pattern_r, len_r, overlap_r; clear history and fill; match=0 that cycle.
  - The in_bit present that cycle is discarded, even if in_valid=1.
  - cfg_err <= (cfg_len==0) || (cfg_len>MAX_LEN).
- cfg_err=1: no hits are generated. history and fill still update. The error stays until a legal cfg_load or reset.
- match_count:
  - +1 on every hit; holds at 2^CNT_W-1 (no wrap).
  - clr_count=1 forces 0. clr_count wins over a same-cycle hit: count=0, but the match pulse still fires.
- Reset mid-stream: all partial progress is lost and the configuration returns to the defaults. The first match after reset requires len_r fresh valid bits.
- len_r=1: every valid bit equal to pattern_r[0] produces a match, in both modes.
- Pattern bits above len_r-1 are ignored in the compare.

Test Plan:
- Defaults after reset, in_valid=1 every cycle, stream 1,0,1,1,0,1,1 -> match pulses one cycle after bits 4 and 7; match_count=2.
- cfg_load pattern=8'b0000_0111, len=3, overlap=0; stream 1,1,1,1,1,1 -> match after bits 3 and 6 only; match_count=2. Same stream with overlap=1 -> match after bits 3,4,5,6; match_count=4.
- Stream 1,0,1,1 with in_valid low for 3 idle cycles between bits 2 and 3 -> exactly one match, one cycle after bit 4. Idle cycles cause no match and no reset of progress.
- cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1 (if representable) -> cfg_err=1 and no match on any stream. A following legal load (len=4, 1011) -> cfg_err=0 and detection resumes.
- Force match_count to 2^CNT_W-1 using CNT_W=4 and 16 matches -> count holds at 15. clr_count asserted on a hit cycle -> count=0 and match=1.
- Feed bits 1,0,1, assert rstn=0 for 1 cycle, then feed 1 -> no match. Then feed 0,1,1 -> match after that bit 4.
